// File: rtl/axi4_ddr3_bridge.sv
// -----------------------------------------------------------------------------
// axi4_ddr3_bridge
//
// Purpose:
//   Connects a typed command/data FIFO interface on the SoC side to the user
//   (app_*) port of the Gowin DDR3 controller. The bridge turns two kinds of
//   requests into controller traffic:
//   - Write bursts: a CMD beat carrying beat 0, then WT beats.
//   - Read bursts: a single RD beat.
//   The controller has no back-pressure on read data, so returned beats land
//   in an internal response FIFO. A read is admitted only when that FIFO has
//   room for the whole burst, so the FIFO can never overflow.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   io_fifo_cmd_*                   command/data beats in (valid/ready)
//   io_fifo_rsp_*                   read data out (ready = data available,
//                                   valid = consumer takes the head)
//   io_app_cmd/_en/_addr/_burst_number, io_app_cmd_ready
//                                   controller command channel
//   io_app_wdata/_en/_end/_mask, io_app_wdata_ready
//                                   controller write data channel
//   io_app_rdata/_valid/_end        controller read data channel
//   io_app_init_calib_complete      controller calibrated; gates new requests
// -----------------------------------------------------------------------------
module axi4_ddr3_bridge #(
    parameter int TYPE_WIDTH = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int BRST_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int RSP_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    // user command/data side
    input  logic                  io_fifo_cmd_valid,
    output logic                  io_fifo_cmd_ready,
    input  logic [TYPE_WIDTH-1:0] io_fifo_cmd_type,
    input  logic [ADDR_WIDTH-1:0] io_fifo_cmd_addr,
    input  logic [BRST_WIDTH-1:0] io_fifo_cmd_burst_cnt,
    input  logic [DATA_WIDTH-1:0] io_fifo_cmd_wt_data,
    input  logic [MASK_WIDTH-1:0] io_fifo_cmd_wt_mask,
    // user response side
    input  logic                  io_fifo_rsp_valid,
    output logic                  io_fifo_rsp_ready,
    output logic [DATA_WIDTH-1:0] io_fifo_rsp_data,
    // controller app port
    output logic [BRST_WIDTH-1:0] io_app_burst_number,
    input  logic                  io_app_cmd_ready,
    output logic [2:0]            io_app_cmd,
    output logic                  io_app_cmd_en,
    output logic [ADDR_WIDTH-1:0] io_app_addr,
    input  logic                  io_app_wdata_ready,
    output logic [DATA_WIDTH-1:0] io_app_wdata,
    output logic                  io_app_wdata_en,
    output logic                  io_app_wdata_end,
    output logic [MASK_WIDTH-1:0] io_app_wdata_mask,
    input  logic [DATA_WIDTH-1:0] io_app_rdata,
    input  logic                  io_app_rdata_valid,
    input  logic                  io_app_rdata_end,
    input  logic                  io_app_init_calib_complete
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [TYPE_WIDTH-1:0] TYPE_IDLE = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] TYPE_CMD  = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TYPE_WT   = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] TYPE_RD   = TYPE_WIDTH'(3);

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_CMD,
        ST_RD_DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BRST_WIDTH-1:0]  last_q, last_d;     // beats-1 of the latched burst
    logic [BRST_WIDTH-1:0]  beat_q, beat_d;     // beat index k within the burst
    logic [DATA_WIDTH-1:0]  beat0_data_q, beat0_data_d;
    logic [MASK_WIDTH-1:0]  beat0_mask_q, beat0_mask_d;

    // ------------------------------------------------------------------
    // Response FIFO: extra pointer bit distinguishes full from empty.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  rsp_mem [RSP_DEPTH];
    logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       rsp_count;
    logic [CNT_W-1:0]       rsp_free;
    logic                   rsp_empty;
    logic                   rsp_push;
    logic                   rsp_pop;

    assign rsp_count = wr_ptr_q - rd_ptr_q;
    assign rsp_free  = CNT_W'(RSP_DEPTH) - rsp_count;
    assign rsp_empty = (rsp_count == '0);
    assign rsp_push  = (state_q == ST_RD_DATA) && io_app_rdata_valid;
    assign rsp_pop   = io_fifo_rsp_valid && !rsp_empty;
    assign wr_ptr_d  = rsp_push ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
    assign rd_ptr_d  = rsp_pop  ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;

    assign io_fifo_rsp_ready = !rsp_empty;
    // Storage is not reset, so mask the head while empty to keep the
    // output clean after reset.
    assign io_fifo_rsp_data  = rsp_empty ? '0 : rsp_mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem[wr_ptr_q[PTR_W-1:0]] <= io_app_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [BRST_WIDTH:0]   n_in;      // beats in the offered burst, 0 -> 1
    logic [BRST_WIDTH-1:0] last_in;   // n_in - 1
    logic                  rd_fits;

    assign n_in    = (io_fifo_cmd_burst_cnt == '0) ? (BRST_WIDTH+1)'(1)
                                                   : {1'b0, io_fifo_cmd_burst_cnt};
    assign last_in = (io_fifo_cmd_burst_cnt == '0) ? '0
                                                   : io_fifo_cmd_burst_cnt - BRST_WIDTH'(1);
    assign rd_fits = (32'(rsp_free) >= 32'(n_in));

    // Controller read-end flag is not needed: the beat counter already
    // knows where the burst stops.
    logic unused_rdata_end;
    assign unused_rdata_end = io_app_rdata_end;

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        last_d            = last_q;
        beat_d            = beat_q;
        beat0_data_d      = beat0_data_q;
        beat0_mask_d      = beat0_mask_q;
        io_fifo_cmd_ready = 1'b0;
        io_app_cmd_en     = 1'b0;
        io_app_cmd        = APP_CMD_WR;
        io_app_wdata_en   = 1'b0;
        io_app_wdata_end  = 1'b0;
        io_app_wdata      = '0;
        io_app_wdata_mask = '0;

        unique case (state_q)
            ST_IDLE: begin
                // rstn gates ready so the port is quiet while reset is held,
                // even though IDLE normally reflects calibration directly.
                io_fifo_cmd_ready = io_app_init_calib_complete && rstn &&
                                    ((io_fifo_cmd_type != TYPE_RD) || rd_fits);
                if (io_fifo_cmd_valid && io_fifo_cmd_ready) begin
                    if (io_fifo_cmd_type == TYPE_CMD) begin
                        addr_d       = io_fifo_cmd_addr;
                        last_d       = last_in;
                        beat0_data_d = io_fifo_cmd_wt_data;
                        beat0_mask_d = io_fifo_cmd_wt_mask;
                        state_d      = ST_WR_CMD;
                    end else if (io_fifo_cmd_type == TYPE_RD) begin
                        addr_d  = io_fifo_cmd_addr;
                        last_d  = last_in;
                        state_d = ST_RD_CMD;
                    end
                    // TYPE_IDLE and stray TYPE_WT beats are consumed and dropped.
                end
            end

            ST_WR_CMD: begin
                io_app_cmd_en = 1'b1;
                io_app_cmd    = APP_CMD_WR;
                if (io_app_cmd_ready) begin
                    beat_d  = '0;
                    state_d = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (beat_q == '0) begin
                    // Beat 0 arrived with the CMD beat and sits in the buffer.
                    io_app_wdata      = beat0_data_q;
                    io_app_wdata_mask = beat0_mask_q;
                    io_app_wdata_en   = io_app_wdata_ready;
                end else begin
                    // Later beats stream straight through; anything other than
                    // WT is held off until the burst completes.
                    io_app_wdata      = io_fifo_cmd_wt_data;
                    io_app_wdata_mask = io_fifo_cmd_wt_mask;
                    io_fifo_cmd_ready = io_app_wdata_ready && (io_fifo_cmd_type == TYPE_WT);
                    io_app_wdata_en   = io_fifo_cmd_valid && io_fifo_cmd_ready;
                end
                io_app_wdata_end = io_app_wdata_en && (beat_q == last_q);
                if (io_app_wdata_en) begin
                    if (beat_q == last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BRST_WIDTH'(1);
                    end
                end
            end

            ST_RD_CMD: begin
                io_app_cmd_en = 1'b1;
                io_app_cmd    = APP_CMD_RD;
                if (io_app_cmd_ready) begin
                    beat_d  = '0;
                    state_d = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (io_app_rdata_valid) begin
                    if (beat_q == last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BRST_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io_app_addr         = addr_q;
    assign io_app_burst_number = last_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            last_q       <= '0;
            beat_q       <= '0;
            beat0_data_q <= '0;
            beat0_mask_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            beat_q       <= beat_d;
            beat0_data_q <= beat0_data_d;
            beat0_mask_q <= beat0_mask_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_axi4_ddr3_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi4_ddr3_bridge
//
// Directed and randomized bench for axi4_ddr3_bridge. The bench plays the
// DDR3 controller: a word-addressed memory array that stores whatever write
// beats the bridge emits and returns read beats from it. A separate reference
// array holds what the user side asked to write. Expected read data comes from
// that reference array, so data corrupted anywhere in the write or read path
// shows up at the response port.
// -----------------------------------------------------------------------------
module tb_axi4_ddr3_bridge;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn;
    logic         io_fifo_cmd_valid;
    logic         io_fifo_cmd_ready;
    logic [1:0]   io_fifo_cmd_type;
    logic [26:0]  io_fifo_cmd_addr;
    logic [5:0]   io_fifo_cmd_burst_cnt;
    logic [127:0] io_fifo_cmd_wt_data;
    logic [15:0]  io_fifo_cmd_wt_mask;
    logic         io_fifo_rsp_valid;
    logic         io_fifo_rsp_ready;
    logic [127:0] io_fifo_rsp_data;
    logic [5:0]   io_app_burst_number;
    logic         io_app_cmd_ready;
    logic [2:0]   io_app_cmd;
    logic         io_app_cmd_en;
    logic [26:0]  io_app_addr;
    logic         io_app_wdata_ready;
    logic [127:0] io_app_wdata;
    logic         io_app_wdata_en;
    logic         io_app_wdata_end;
    logic [15:0]  io_app_wdata_mask;
    logic [127:0] io_app_rdata;
    logic         io_app_rdata_valid;
    logic         io_app_rdata_end;
    logic         io_app_init_calib_complete;

    axi4_ddr3_bridge dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .io_fifo_cmd_valid          (io_fifo_cmd_valid),
        .io_fifo_cmd_ready          (io_fifo_cmd_ready),
        .io_fifo_cmd_type           (io_fifo_cmd_type),
        .io_fifo_cmd_addr           (io_fifo_cmd_addr),
        .io_fifo_cmd_burst_cnt      (io_fifo_cmd_burst_cnt),
        .io_fifo_cmd_wt_data        (io_fifo_cmd_wt_data),
        .io_fifo_cmd_wt_mask        (io_fifo_cmd_wt_mask),
        .io_fifo_rsp_valid          (io_fifo_rsp_valid),
        .io_fifo_rsp_ready          (io_fifo_rsp_ready),
        .io_fifo_rsp_data           (io_fifo_rsp_data),
        .io_app_burst_number        (io_app_burst_number),
        .io_app_cmd_ready           (io_app_cmd_ready),
        .io_app_cmd                 (io_app_cmd),
        .io_app_cmd_en              (io_app_cmd_en),
        .io_app_addr                (io_app_addr),
        .io_app_wdata_ready         (io_app_wdata_ready),
        .io_app_wdata               (io_app_wdata),
        .io_app_wdata_en            (io_app_wdata_en),
        .io_app_wdata_end           (io_app_wdata_end),
        .io_app_wdata_mask          (io_app_wdata_mask),
        .io_app_rdata               (io_app_rdata),
        .io_app_rdata_valid         (io_app_rdata_valid),
        .io_app_rdata_end           (io_app_rdata_end),
        .io_app_init_calib_complete (io_app_init_calib_complete)
    );

    typedef struct packed {
        logic [2:0]  cmd;
        logic [26:0] addr;
        logic [5:0]  bn;
    } cmd_t;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  m;
        logic         e;
    } wr_t;

    cmd_t         cmd_obs[$];     // commands the controller accepted
    wr_t          wr_obs[$];      // write beats the controller accepted
    logic [127:0] rsp_exp[$];     // read data the user side should receive
    logic [127:0] pend_rd[$];     // beats the controller model still owes
    logic [127:0] ref_mem [1024]; // what the user side wrote
    logic [127:0] ddr_mem [1024]; // what the bridge actually delivered

    int           cur_wr_addr;
    int           wr_idx;
    bit           rand_ready;     // randomize controller readies
    int           rsp_mode;       // 0 hold, 1 always consume, 2 random
    bit           hold_pending;
    logic [26:0]  hold_addr;
    logic [2:0]   hold_cmd;

    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input bit cond);
        checks++;
        assert (cond) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {io_fifo_cmd_ready, io_fifo_rsp_ready, io_app_cmd_en,
                            io_app_wdata_en, io_app_wdata_end, io_app_cmd,
                            io_app_burst_number, io_app_addr}, '0);
        chk({tag, "_wdata"}, io_app_wdata, '0);
        chk({tag, "_wmask"}, io_app_wdata_mask, '0);
        chk({tag, "_rspdata"}, io_fifo_rsp_data, '0);
    endtask

    // One clock cycle. Enters at posedge+1; outputs are sampled at posedge+3,
    // handshakes that complete at the coming edge are recorded, then the
    // controller-side inputs are driven at the next posedge+1.
    task automatic tick(output bit acc);
        cmd_t c;
        wr_t  w;
        int   idx;
        #2;
        acc = io_fifo_cmd_valid && io_fifo_cmd_ready;
        if (hold_pending) begin
            chk("cmd_en_hold", {io_app_cmd_en, io_app_cmd, io_app_addr},
                               {1'b1, hold_cmd, hold_addr});
        end
        hold_pending = io_app_cmd_en && !io_app_cmd_ready;
        hold_addr    = io_app_addr;
        hold_cmd     = io_app_cmd;
        if (io_app_cmd_en && io_app_cmd_ready) begin
            c = {io_app_cmd, io_app_addr, io_app_burst_number};
            cmd_obs.push_back(c);
            if (io_app_cmd == 3'b001) begin
                for (int i = 0; i <= int'(io_app_burst_number); i++) begin
                    idx = (int'(io_app_addr) + i) & 1023;
                    pend_rd.push_back(ddr_mem[idx]);
                end
            end else begin
                cur_wr_addr = int'(io_app_addr);
                wr_idx      = 0;
            end
        end
        if (io_app_wdata_en) begin
            w = {io_app_wdata, io_app_wdata_mask, io_app_wdata_end};
            wr_obs.push_back(w);
            ddr_mem[(cur_wr_addr + wr_idx) & 1023] = io_app_wdata;
            wr_idx++;
        end
        if (io_fifo_rsp_valid && io_fifo_rsp_ready) begin
            if (rsp_exp.size() > 0) begin
                chk("rsp_data", io_fifo_rsp_data, rsp_exp.pop_front());
            end else begin
                checks++;
                errors++;
                $error("FAIL rsp_unexpected observed=%0h expected=no data", io_fifo_rsp_data);
            end
        end
        @(posedge clk);
        #1;
        io_app_cmd_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        io_app_wdata_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend_rd.size() > 0 && (!rand_ready || $urandom_range(0, 2) != 0)) begin
            io_app_rdata       = pend_rd.pop_front();
            io_app_rdata_valid = 1'b1;
            io_app_rdata_end   = (pend_rd.size() == 0);
        end else begin
            io_app_rdata       = {$urandom, $urandom, $urandom, $urandom};
            io_app_rdata_valid = 1'b0;
            io_app_rdata_end   = 1'b0;
        end
        if (rsp_mode == 0)      io_fifo_rsp_valid = 1'b0;
        else if (rsp_mode == 1) io_fifo_rsp_valid = 1'b1;
        else                    io_fifo_rsp_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic ticks(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send_beat(input string tag, input logic [1:0] t, input logic [26:0] a,
                             input logic [5:0] bc, input logic [127:0] d, input logic [15:0] m);
        bit acc;
        int cyc;
        io_fifo_cmd_valid     = 1'b1;
        io_fifo_cmd_type      = t;
        io_fifo_cmd_addr      = a;
        io_fifo_cmd_burst_cnt = bc;
        io_fifo_cmd_wt_data   = d;
        io_fifo_cmd_wt_mask   = m;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 600) begin
            tick(acc);
            cyc++;
        end
        chk_true({tag, "_accept"}, acc);
        io_fifo_cmd_valid = 1'b0;
        io_fifo_cmd_type  = 2'd0;
    endtask

    task automatic do_write(input logic [26:0] a, input logic [5:0] bc,
                            input logic [127:0] d0, input logic [15:0] m0, input bit rnd);
        int           n;
        int           cyc;
        bit           acc;
        logic [127:0] d[$];
        logic [15:0]  m[$];
        cmd_t         c;
        wr_t          w;
        n = (bc == 6'd0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                d.push_back({$urandom, $urandom, $urandom, $urandom});
                m.push_back(16'($urandom));
            end else begin
                d.push_back(d0 + 128'(i));
                m.push_back(m0 << i);
            end
        end
        send_beat("wr_cmd", 2'd1, a, bc, d[0], m[0]);
        for (int i = 1; i < n; i++) begin
            send_beat("wr_wt", 2'd2, 27'($urandom), 6'($urandom), d[i], m[i]);
        end
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) & 1023] = d[i];
        cyc = 0;
        while ((wr_obs.size() < n || cmd_obs.size() < 1) && cyc < 300) begin
            tick(acc);
            cyc++;
        end
        chk_true("wr_complete", (wr_obs.size() >= n) && (cmd_obs.size() >= 1));
        if (cmd_obs.size() > 0) begin
            c = cmd_obs.pop_front();
            chk("wr_app_cmd", {c.cmd, c.addr, c.bn}, {3'b000, a, 6'(n - 1)});
        end
        for (int i = 0; i < n; i++) begin
            if (wr_obs.size() > 0) begin
                w = wr_obs.pop_front();
                chk("wr_beat", {w.d, w.m, w.e}, {d[i], m[i], (i == n - 1)});
            end
        end
        chk("wr_extra_beats", 160'(wr_obs.size()), '0);
    endtask

    task automatic do_read(input logic [26:0] a, input logic [5:0] bc, input bit drain);
        int   n;
        int   cyc;
        bit   acc;
        cmd_t c;
        n = (bc == 6'd0) ? 1 : int'(bc);
        send_beat("rd", 2'd3, a, bc, '0, '0);
        for (int i = 0; i < n; i++) rsp_exp.push_back(ref_mem[(int'(a) + i) & 1023]);
        cyc = 0;
        while (cmd_obs.size() == 0 && cyc < 300) begin
            tick(acc);
            cyc++;
        end
        chk_true("rd_cmd_seen", cmd_obs.size() > 0);
        if (cmd_obs.size() > 0) begin
            c = cmd_obs.pop_front();
            chk("rd_app_cmd", {c.cmd, c.addr, c.bn}, {3'b001, a, 6'(n - 1)});
        end
        if (drain) begin
            cyc = 0;
            while (rsp_exp.size() > 0 && cyc < 600) begin
                tick(acc);
                cyc++;
            end
            chk_true("rd_drained", rsp_exp.size() == 0);
        end
    endtask

    task automatic wait_rd_returned();
        bit acc;
        int cyc;
        cyc = 0;
        while (pend_rd.size() > 0 && cyc < 300) begin
            tick(acc);
            cyc++;
        end
        chk_true("rd_returned", pend_rd.size() == 0);
        ticks(2);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int op;
        int cyc;

        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            ddr_mem[i] = ref_mem[i];
        end
        rand_ready   = 1'b0;
        rsp_mode     = 0;
        hold_pending = 1'b0;
        rstn                       = 1'b0;
        io_fifo_cmd_valid          = 1'b0;
        io_fifo_cmd_type           = 2'd0;
        io_fifo_cmd_addr           = '0;
        io_fifo_cmd_burst_cnt      = '0;
        io_fifo_cmd_wt_data        = '0;
        io_fifo_cmd_wt_mask        = '0;
        io_fifo_rsp_valid          = 1'b0;
        io_app_cmd_ready           = 1'b1;
        io_app_wdata_ready         = 1'b1;
        io_app_rdata               = '0;
        io_app_rdata_valid         = 1'b0;
        io_app_rdata_end           = 1'b0;
        io_app_init_calib_complete = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk_quiet("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Not calibrated: nothing accepted
        io_fifo_cmd_valid = 1'b1;
        io_fifo_cmd_type  = 2'd0;
        ticks(2);
        #1;
        chk("nocalib_ready", 160'(io_fifo_cmd_ready), 160'(0));
        io_fifo_cmd_valid = 1'b0;

        // Calibrated: IDLE beat accepted without any controller activity
        io_app_init_calib_complete = 1'b1;
        send_beat("idle_beat", 2'd0, 27'd5, 6'd3, 128'h1, 16'h1);
        ticks(4);
        chk("idle_no_app", 160'(cmd_obs.size() + wr_obs.size()), '0);

        // Directed 8-beat write at address 0
        do_write(27'd0, 6'd8, 128'h0123456789abcdeffedcba9876543210, 16'h0001, 1'b0);

        // Stray WT in IDLE is consumed and dropped
        send_beat("stray_wt", 2'd2, 27'd0, 6'd0, 128'hdead, 16'hffff);
        ticks(4);
        chk("stray_no_app", 160'(cmd_obs.size() + wr_obs.size()), '0);

        // Directed 4-beat read of what was just written
        rsp_mode = 1;
        io_fifo_rsp_valid = 1'b1;
        do_read(27'd0, 6'd4, 1'b1);

        // Held responses fill half the FIFO; a 40-beat read must wait
        rsp_mode = 0;
        io_fifo_rsp_valid = 1'b0;
        do_read(27'd200, 6'd32, 1'b0);
        wait_rd_returned();
        chk("rsp_held_ready", 160'(io_fifo_rsp_ready), 160'(1));
        chk("rsp_held_head", io_fifo_rsp_data, rsp_exp[0]);
        io_fifo_cmd_valid     = 1'b1;
        io_fifo_cmd_type      = 2'd3;
        io_fifo_cmd_addr      = 27'd400;
        io_fifo_cmd_burst_cnt = 6'd40;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rd_admit_blocked", 160'(io_fifo_cmd_ready), 160'(0));
            tick(acc);
        end
        chk("rd_blocked_no_cmd", 160'(cmd_obs.size()), '0);
        rsp_mode = 1;
        io_fifo_rsp_valid = 1'b1;
        do_read(27'd400, 6'd40, 1'b1);

        // Burst of zero length behaves as one beat
        do_write(27'd600, 6'd0, 128'h55aa, 16'h8001, 1'b0);
        do_read(27'd600, 6'd0, 1'b1);

        // Randomized traffic with stalling controller and consumer
        rand_ready = 1'b1;
        rsp_mode   = 2;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 5);
            if (op <= 2) begin
                do_write(27'($urandom_range(0, 900)), 6'($urandom_range(0, 63)), '0, '0, 1'b1);
            end else if (op <= 4) begin
                do_read(27'($urandom_range(0, 900)), 6'($urandom_range(0, 63)), 1'b0);
            end else begin
                send_beat("rand_stray", ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2,
                          27'($urandom), 6'($urandom), 128'($urandom), 16'($urandom));
                ticks(3);
                chk("rand_stray_no_app", 160'(cmd_obs.size() + wr_obs.size()), '0);
            end
        end
        rsp_mode = 1;
        cyc = 0;
        while ((rsp_exp.size() > 0 || pend_rd.size() > 0) && cyc < 3000) begin
            tick(acc);
            cyc++;
        end
        chk_true("final_drain", (rsp_exp.size() == 0) && (pend_rd.size() == 0));
        ticks(2);
        chk("final_rsp_empty", 160'(io_fifo_rsp_ready), 160'(0));

        // Reset in the middle of a write burst with responses still buffered
        rand_ready = 1'b0;
        rsp_mode   = 0;
        io_fifo_rsp_valid = 1'b0;
        ticks(1);
        do_read(27'd300, 6'd5, 1'b0);
        wait_rd_returned();
        send_beat("rst_cmd", 2'd1, 27'd10, 6'd8, 128'h1111, 16'h00ff);
        send_beat("rst_wt1", 2'd2, 27'd0, 6'd0, 128'h2222, 16'h00ff);
        send_beat("rst_wt2", 2'd2, 27'd0, 6'd0, 128'h3333, 16'h00ff);
        io_fifo_cmd_valid   = 1'b1;
        io_fifo_cmd_type    = 2'd2;
        io_fifo_cmd_wt_data = 128'h4444;
        io_fifo_cmd_wt_mask = 16'hffff;
        #1;
        chk("pre_reset_wdata_en", 160'(io_app_wdata_en), 160'(1));
        rstn = 1'b0;
        #1;
        chk_quiet("reset_mid");
        ticks(2);
        rstn = 1'b1;
        cmd_obs.delete();
        wr_obs.delete();
        rsp_exp.delete();
        pend_rd.delete();
        hold_pending = 1'b0;
        io_fifo_cmd_type = 2'd0;
        #1;
        chk("post_reset_ready", 160'({io_fifo_cmd_ready, io_fifo_rsp_ready}), 160'(2'b10));
        io_fifo_cmd_valid = 1'b0;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
